// File: rtl/fetch_stage.sv
// Instruction-fetch stage: one imem request per PC, IF/ID register,
// decode back-pressure, flush/redirect and a fetch-timeout watchdog.
module fetch_stage #(
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned COUNT_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            pcAddress,
  output logic                   pcEnable,
  output logic                   imemReq,
  output logic [31:0]            imemAddr,
  input  logic                   imemValid,
  input  logic [31:0]            imemData,
  input  logic                   decodeStall,
  input  logic                   flush,
  output logic                   ifidValid,
  output logic [31:0]            ifidInstruction,
  output logic [31:0]            ifidPcPlus4,
  output logic                   fetchError,
  output logic [COUNT_WIDTH-1:0] fetchCount
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_DROP
  } state_e;

  state_e                 state_q, state_d;
  logic                   ifid_valid_q, ifid_valid_d;
  logic [31:0]            ifid_instr_q, ifid_instr_d;
  logic [31:0]            ifid_pc4_q, ifid_pc4_d;
  logic [31:0]            hold_instr_q, hold_instr_d;
  logic [31:0]            hold_pc4_q, hold_pc4_d;
  logic                   err_q, err_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [TW-1:0]          tmo_q, tmo_d;

  logic        accept;
  logic        pc_en;
  logic [31:0] pc_plus4;

  always_comb begin
    accept       = !decodeStall || !ifid_valid_q;
    pc_plus4     = pcAddress + 32'd4;
    pc_en        = 1'b0;
    state_d      = state_q;
    ifid_valid_d = ifid_valid_q && decodeStall;
    ifid_instr_d = ifid_valid_d ? ifid_instr_q : NOP_INSTR;
    ifid_pc4_d   = ifid_pc4_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    count_d      = count_q;
    if (flush) begin
      pc_en        = 1'b1;
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
      case (state_q)
        S_FETCH: if (!imemValid) state_d = S_DROP;
        S_HOLD:  state_d = S_FETCH;
        default: state_d = state_q;
      endcase
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imemValid) begin
            if (accept) begin
              pc_en        = 1'b1;
              ifid_valid_d = 1'b1;
              ifid_instr_d = imemData;
              ifid_pc4_d   = pc_plus4;
              count_d      = count_q + COUNT_WIDTH'(1);
            end else begin
              hold_instr_d = imemData;
              hold_pc4_d   = pc_plus4;
              state_d      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (accept) begin
            pc_en        = 1'b1;
            ifid_valid_d = 1'b1;
            ifid_instr_d = hold_instr_q;
            ifid_pc4_d   = hold_pc4_q;
            count_d      = count_q + COUNT_WIDTH'(1);
            state_d      = S_FETCH;
          end
        end
        S_DROP: if (imemValid) state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end
    // Watchdog only runs while waiting on memory in an unchanged state
    tmo_d = '0;
    err_d = err_q;
    if (state_d == state_q && state_q != S_HOLD && !imemValid) begin
      tmo_d = (tmo_q == T_MAX) ? tmo_q : tmo_q + TW'(1);
      if (tmo_d == T_MAX) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FETCH;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= '0;
      hold_instr_q <= '0;
      hold_pc4_q   <= '0;
      err_q        <= 1'b0;
      count_q      <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
      err_q        <= err_d;
      count_q      <= count_d;
      tmo_q        <= tmo_d;
    end
  end

  assign imemReq         = reset && (state_q == S_FETCH);
  assign pcEnable        = reset && pc_en;
  assign imemAddr        = imemReq ? pcAddress : 32'h0;
  assign ifidValid       = ifid_valid_q;
  assign ifidInstruction = ifid_instr_q;
  assign ifidPcPlus4     = ifid_pc4_q;
  assign fetchError      = err_q;
  assign fetchCount      = count_q;

endmodule
